// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mult_pkg                                                          |
// | Desc   : Shared constants, counter-width helper and strobe encoding for    |
// |          the shift-add multiplier datapath.                                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mult_pkg;

   // Default operand width; product is twice this.
   localparam int DEFAULT_WIDTH = 4;

   // Iteration counter width. Guarded so WIDTH=1 cannot yield a zero-width vector.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   // Decoded view of the three Control strobes.
   typedef enum logic [2:0] {
      LOAD      = 3'd0,
      ADD       = 3'd1,
      SHIFT     = 3'd2,
      ADD_SHIFT = 3'd3,
      IDLE      = 3'd4
   } strobe_e;

   // Load dominates; Ad and Sh together mean add-then-shift in one cycle.
   function automatic strobe_e decode_strobe(input logic load, input logic ad, input logic sh);
      if (load)           return LOAD;
      else if (ad && sh)  return ADD_SHIFT;
      else if (ad)        return ADD;
      else if (sh)        return SHIFT;
      else                return IDLE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_datapath_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mult_datapath_if                                                  |
// | Desc   : Control <-> datapath bundle for the shift-add multiplier.         |
// |          master (Control side): drives load/ad/sh/mcand/mplier[/done],     |
// |                                 receives m, k, product.                    |
// |          slave  (datapath)    : the mirror image.                          |
// |          Macro MULT_PRODUCT_HOLD_EN adds the done strobe.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface mult_datapath_if
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic                 load;
   logic                 ad;
   logic                 sh;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 m;
   logic                 k;
   logic [2*WIDTH-1:0]   product;
`ifdef MULT_PRODUCT_HOLD_EN
   logic                 done;

   modport master (output load, ad, sh, mcand, mplier, done,
                   input  m, k, product);
   modport slave  (input  load, ad, sh, mcand, mplier, done,
                   output m, k, product);
`else
   modport master (output load, ad, sh, mcand, mplier,
                   input  m, k, product);
   modport slave  (input  load, ad, sh, mcand, mplier,
                   output m, k, product);
`endif

endinterface
`default_nettype wire

// File: rtl/mult_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mult_counter                                                      |
// | Desc   : Mod-WIDTH iteration counter for the shift-add multiplier.         |
// |          clk, rst_n (async, active-low)                                    |
// |          i_clr : synchronous clear (Load), dominates i_inc                 |
// |          i_inc : advance by one (Sh), wraps WIDTH-1 -> 0                   |
// |          o_k   : high while count == WIDTH-1 (last iteration)              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mult_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = cnt_w(WIDTH)
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_clr,
   input  wire logic i_inc,
   output logic      o_k
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         // Explicit wrap: WIDTH need not be a power of two.
         r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign o_k = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mult_datapath                                                     |
// | Desc   : Shift-add multiplier datapath. Holds the accumulator/multiplier   |
// |          shift register (with a carry MSB), the multiplicand copy and the  |
// |          iteration counter; returns M/K status to Control.                 |
// |          clk   : rising-edge clock                                         |
// |          rst_n : async active-low reset                                    |
// |          bus   : mult_datapath_if.slave (load/ad/sh/mcand/mplier in,       |
// |                  m/k/product out; done in when MULT_PRODUCT_HOLD_EN)       |
// |          Macro MULT_PRODUCT_HOLD_EN: product comes from a holding register |
// |          refreshed by done, so it survives the next Load.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   mult_datapath_if.slave   bus
);

   localparam int W = WIDTH;

   // r_acc[2W] catches the add carry; it is consumed by the following shift.
   logic [2*W:0]   r_acc;
   logic [W-1:0]   r_mc;
   logic [2*W:0]   w_acc_nxt;
   logic [W:0]     w_sum;
   logic           w_k;
   strobe_e        w_strobe;

   assign w_strobe = decode_strobe(bus.load, bus.ad, bus.sh);

   // Upper half excludes the carry bit: every add is preceded by a shift in
   // normal operation, so the carry is already zero here.
   assign w_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mc};

   always_comb begin
      w_acc_nxt = r_acc;
      case (w_strobe)
         LOAD:      w_acc_nxt = {{(W+1){1'b0}}, bus.mplier};
         ADD:       w_acc_nxt = {w_sum, r_acc[W-1:0]};
         SHIFT:     w_acc_nxt = {1'b0, r_acc[2*W:1]};
         ADD_SHIFT: w_acc_nxt = {1'b0, w_sum, r_acc[W-1:1]};
         default:   w_acc_nxt = r_acc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_mc  <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         if (bus.load) begin
            r_mc <= bus.mcand;
         end
      end
   end

   mult_counter #(
      .WIDTH (W)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (bus.load),
      .i_inc (bus.sh),
      .o_k   (w_k)
   );

   assign bus.m = r_acc[0];
   assign bus.k = w_k;

`ifdef MULT_PRODUCT_HOLD_EN
   logic [2*W-1:0] r_phold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phold <= '0;
      end else if (bus.done) begin
         r_phold <= r_acc[2*W-1:0];
      end
   end

   assign bus.product = r_phold;
`else
   assign bus.product = r_acc[2*W-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mult_datapath                                                  |
// | Desc   : Scoreboard bench for mult_datapath. The driver updates an         |
// |          arithmetic model of the multiplier state on every issued cycle    |
// |          and queues the expected outputs; a monitor pops and compares one  |
// |          entry per clock, #1 after the rising edge. Directed checks add    |
// |          spec-derived constant products. Honours MULT_PRODUCT_HOLD_EN.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mult_datapath;
   import mult_pkg::*;

   localparam int W = 4;
   localparam longint unsigned MODW = 64'd1 << W;
   localparam longint unsigned PW   = 64'd1 << (2*W);

   logic clk;
   logic rst_n;

   mult_datapath_if #(.WIDTH(W)) bus ();

   mult_datapath #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit              m;
      bit              k;
      bit              c;
      longint unsigned p;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Behavioural model: the accumulator is a plain number, shifts are halving.
   longint unsigned md_acc, md_mc, md_phold;
   int              md_cnt;

   function automatic void model_reset();
      md_acc = 0; md_mc = 0; md_phold = 0; md_cnt = 0;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.m = bit'(md_acc % 2);
      e.k = (md_cnt == W - 1);
      e.c = bit'((md_acc >> (2*W)) & 1);
`ifdef MULT_PRODUCT_HOLD_EN
      e.p = md_phold;
`else
      e.p = md_acc % PW;
`endif
      return e;
   endfunction

   function automatic void model_edge(input bit ld, input bit ad, input bit sh,
                                      input longint unsigned mc, input longint unsigned mp,
                                      input bit dn);
`ifdef MULT_PRODUCT_HOLD_EN
      if (dn) md_phold = md_acc % PW;
`else
      if (dn) md_phold = 0;
`endif
      if (ld) begin
         md_acc = mp;
         md_mc  = mc;
         md_cnt = 0;
      end else begin
         if (ad) md_acc = (md_acc % MODW) + ((((md_acc / MODW) % MODW) + md_mc) * MODW);
         if (sh) begin
            md_acc = md_acc / 2;
            md_cnt = (md_cnt + 1) % W;
         end
      end
   endfunction

   task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // One issued cycle: inputs change on the falling edge, take effect on the next rising edge.
   task automatic drive(input bit ld, input bit ad, input bit sh,
                        input int unsigned mc, input int unsigned mp,
                        input bit dn, input bit rst);
      @(negedge clk);
      rst_n      = rst;
      bus.load   = ld;
      bus.ad     = ad;
      bus.sh     = sh;
      bus.mcand  = W'(mc);
      bus.mplier = W'(mp);
`ifdef MULT_PRODUCT_HOLD_EN
      bus.done   = dn;
`endif
      if (!rst) model_reset();
      else      model_edge(ld, ad, sh, longint'(W'(mc)), longint'(W'(mp)), dn);
      exp_q.push_back(model_out());
   endtask

   task automatic op(input bit ld, input bit ad, input bit sh, input int unsigned mc, input int unsigned mp);
      drive(ld, ad, sh, mc, mp, 1'b0, 1'b1);
   endtask

   task automatic load_ops(input int unsigned a, input int unsigned b);
      op(1'b1, 1'b0, 1'b0, a, b);
   endtask

   // Control-FSM style iterations, deciding Ad from the model's multiplier LSB.
   task automatic control_iters(input int n, input bit combined);
      for (int i = 0; i < n; i++) begin
         if (md_acc % 2 == 1) begin
            if (combined) op(1'b0, 1'b1, 1'b1, 0, 0);
            else begin
               op(1'b0, 1'b1, 1'b0, 0, 0);
               op(1'b0, 1'b0, 1'b1, 0, 0);
            end
         end else begin
            op(1'b0, 1'b0, 1'b1, 0, 0);
         end
      end
   endtask

   task automatic sample();
      @(posedge clk);
      #2;
   endtask

   // Done is a no-op in the default build, so this works for both product paths.
   task automatic finish_check(input string name, input longint unsigned exp);
      drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
      sample();
      check(name, longint'(bus.product), exp);
   endtask

   // Monitor: one output beat per clock.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.m === e.m && bus.k === e.k && dut.r_acc[2*W] === e.c &&
             longint'(bus.product) == e.p) begin
            n_pass++;
         end else begin
            $display("FAIL scoreboard t=%0t: got m=%0b k=%0b c=%0b p=%0d, expected m=%0b k=%0b c=%0b p=%0d",
                     $time, bus.m, bus.k, dut.r_acc[2*W], bus.product, e.m, e.k, e.c, e.p);
         end
      end
   end

   initial begin
      int unsigned a, b;
      int drain;
      rst_n      = 1'b0;
      bus.load   = 1'b0;
      bus.ad     = 1'b0;
      bus.sh     = 1'b0;
      bus.mcand  = '0;
      bus.mplier = '0;
`ifdef MULT_PRODUCT_HOLD_EN
      bus.done   = 1'b0;
`endif
      model_reset();

      // Reset held with random strobes, then release with no Load.
      for (int i = 0; i < 3; i++)
         drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
      op(1'b0, 1'b0, 1'b0, 0, 0);
      op(1'b0, 1'b0, 1'b0, 0, 0);
      sample();
      check("post_reset_product", longint'(bus.product), 0);

      // Basic 13*11 with separate Ad/Sh.
      load_ops(13, 11);
      sample();
      check("load_m", longint'(bus.m), 1);
      control_iters(4, 1'b0);
      sample();
      check("basic_k_after_4th", longint'(bus.k), 0);
      finish_check("basic_13x11", 143);

      // New Load: product is held in hold mode, follows ACC otherwise.
      load_ops(3, 5);
      sample();
`ifdef MULT_PRODUCT_HOLD_EN
      check("hold_across_load", longint'(bus.product), 143);
`else
      check("load_product", longint'(bus.product), 5);
`endif
      control_iters(4, 1'b0);
      finish_check("run_3x5", 15);

      // Carry path: every add taken.
      load_ops(15, 15);
      op(1'b0, 1'b1, 1'b0, 0, 0);
      op(1'b0, 1'b0, 1'b1, 0, 0);
      op(1'b0, 1'b1, 1'b0, 0, 0);
      sample();
      check("carry_iter2", longint'(dut.r_acc[2*W]), 1);
      op(1'b0, 1'b0, 1'b1, 0, 0);
      control_iters(2, 1'b0);
      finish_check("carry_15x15", 225);

      // Single-cycle Ad+Sh.
      load_ops(13, 11);
      control_iters(4, 1'b1);
      finish_check("combined_13x11", 143);

      // Restart mid-multiply with all three strobes high.
      load_ops(13, 11);
      control_iters(2, 1'b0);
      op(1'b1, 1'b1, 1'b1, 3, 5);
      sample();
      check("restart_k", longint'(bus.k), 0);
      check("restart_m", longint'(bus.m), 1);
      control_iters(4, 1'b0);
      finish_check("restart_3x5", 15);

      // Asynchronous reset between edges.
      load_ops(13, 11);
      control_iters(2, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_m", longint'(bus.m), 0);
      check("async_rst_k", longint'(bus.k), 0);
      check("async_rst_product", longint'(bus.product), 0);
      drive(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
      op(1'b0, 1'b0, 1'b0, 0, 0);

      // Random complete multiplies.
      for (int i = 0; i < 20; i++) begin
         a = $urandom_range(0, int'(MODW) - 1);
         b = $urandom_range(0, int'(MODW) - 1);
         load_ops(a, b);
         control_iters(4, 1'($urandom));
         finish_check("random_mult", longint'(a) * longint'(b));
      end

      // Random strobe soup, including stale-state operation.
      for (int i = 0; i < 150; i++)
         drive(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
               $urandom, $urandom, ($urandom_range(0, 5) == 0), 1'b1);

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         sample();
         drain++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Datapath stage for the shift-add multiplier. Sits directly downstream of the Control FSM.
- Consumes the Control FSM's Load, Ad and Sh strobes and returns the M (multiplier LSB) and K (last-iteration) status flags to it.
- Holds the accumulator/multiplier shift register and the iteration counter, and presents the final product.

Parameters:
- WIDTH, 4, operand width in bits (≥2). Product is 2*WIDTH bits.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset (0 = reset).
- Load  input  1  start strobe from Control: load operands, clear counter.
- Ad  input  1  add multiplicand into upper accumulator half.
- Sh  input  1  shift accumulator right by one, advance counter.
- Mcand  input  WIDTH  multiplicand, sampled only when Load=1.
- Mplier  input  WIDTH  multiplier, sampled only when Load=1.
- M  output  1  current multiplier LSB = ACC[0]; feeds Control.
- K  output  1  high while counter == WIDTH-1; feeds Control.
- Product  output  2*WIDTH  ACC[2*WIDTH-1:0].

Behaviour:
- State: ACC[2*WIDTH:0] (extra MSB holds add carry); MC[WIDTH-1:0] multiplicand copy; CNT[$clog2(WIDTH)-1:0].
- Reset (Rst=0, async): ACC=0, MC=0, CNT=0. Therefore M=0, K=0, Product=0. Reset mid-multiply aborts immediately; no partial result is retained.
- Load=1: ACC <= {(WIDTH+1)'b0, Mplier}; MC <= Mcand; CNT <= 0. Load has priority over Ad and Sh in the same cycle.
- Ad=1, Sh=0: ACC[2W:W] <= ACC[2W-1:W] + MC, a WIDTH+1-bit zero-extended sum; ACC[W-1:0] unchanged; CNT unchanged.
- Sh=1, Ad=0: ACC <= {1'b0, ACC[2W:1]}; CNT <= CNT+1. At WIDTH-1 the counter wraps to 0.
- Ad=1 and Sh=1 together: add then shift in one cycle, i.e. ACC <= {1'b0, sum, ACC[W-1:1]}, where sum is the WIDTH+1-bit Ad result; CNT increments.
- No strobe: hold all state.
- M and K are combinational from registers; zero input-to-output combinational path.
- Latency: a strobe's effect is visible on M/K/Product the cycle after the sampling edge.
- Correctness contract: after Load followed by exactly WIDTH Sh strobes (each optionally preceded by or combined with Ad when M=1), Product = Mcand*Mplier. The carry bit cannot be lost because every add is followed by a shift.
- Strobes asserted with no prior Load operate on the reset/stale state; this is not an error.

Optional Feature:
- Macro: MULT_PRODUCT_HOLD_EN.
- Defined:
  - Adds input port Done (1 bit) and a 2*WIDTH holding register PHOLD, reset to 0.
  - On Done=1, PHOLD <= ACC[2W-1:0], and Product is driven from PHOLD.
  - The result therefore stays stable across the next Load until the next Done.
- Undefined: no Done port; Product is taken directly from ACC, and changes as soon as Load/Ad/Sh act.

Decomposition:
- Package mult_pkg:
  - default WIDTH constant;
  - CNT_W = $clog2(WIDTH) localparam function;
  - strobe-encoding typedef {LOAD, ADD, SHIFT, ADD_SHIFT, IDLE} used by datapath and bench.
- Sub-module mult_counter:
  - mod-WIDTH counter with clr (Load), inc (Sh) and K decode;
  - async active-low reset.
- Accumulator stays in the top module.

Test Plan (WIDTH=4 unless noted):
- Reset: Rst=0 for 3 cycles with random strobes → M=0, K=0, Product=0 throughout. Release → outputs stay 0 until Load.
- Basic multiply: Load Mcand=13, Mplier=11 → M=1. Run Control-style sequence (Ad when M=1, then Sh) for 4 shifts → Product=143 (0x8F). K=1 exactly after the 3rd Sh and 0 after the 4th.
- Carry path: Mcand=15, Mplier=15, all four adds taken → Product=225; ACC[2W] observed as 1 after the add in iteration ≥2.
- Combined Ad+Sh: repeat 13*11 using the single-cycle Ad&Sh strobe → Product=143 in 4 cycles after Load.
- Priority/restart: mid-multiply (after 2 Sh), assert Load+Ad+Sh with Mcand=3, Mplier=5 → CNT=0, Product=0x0005; the completed run gives 15.
- Async reset mid-op: drop Rst between clock edges after 2 Sh → outputs 0 before the next edge. With MULT_PRODUCT_HOLD_EN, PHOLD holds 143 across the next Load until Done; Done then updates it to 15 for the 3*5 run.
